change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter INIT_COUNT, default 8, coins of each denomination loaded at reset (0..15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 200, cycles to wait for coin_ack before declaring a jam (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port change_amount  input  5  change owed, units of 1 (0..31).
REQ-006 SHALL have port change_valid  input  1  start request; change_amount is sampled on the same edge.
REQ-007 SHALL have port coin_ack  input  1  ejector has released the current coin.
REQ-008 SHALL have port refill_en  input  1  add one coin to inventory.
REQ-009 SHALL have port refill_sel  input  2  denomination for refill: 0=1, 1=2, 2=5, 3=10.
REQ-010 SHALL have port coin_valid  output  1  coin eject request to the ejector.
REQ-011 SHALL have port coin_sel  output  2  denomination being ejected, same encoding as refill_sel.
REQ-012 SHALL have port dispense_busy  output  1  a dispense is in progress.
REQ-013 SHALL have port dispense_done  output  1  one-cycle pulse when the full amount is paid out.
REQ-014 SHALL have port dispense_error  output  1  one-cycle pulse on shortfall or jam.
REQ-015 SHALL have port remaining  output  5  change not yet paid out.
REQ-016 SHALL have port inv_empty  output  4  bit i high when the denomination-i count is 0.

Function
REQ-017 SHALL use states IDLE, SELECT, EJECT, DONE, ERROR, with all outputs registered.
REQ-018 SHALL hold four 4-bit inventory counters, one per denomination.
REQ-019 IDLE: on change_valid with change_amount>0, SHALL load remaining=change_amount, set busy=1 and go to SELECT on the next edge.
REQ-020 IDLE: on change_valid with change_amount=0, SHALL go to DONE on the next edge.
REQ-021 SHALL ignore change_valid in every state other than IDLE.
REQ-022 SELECT lasts one cycle.
  - remaining=0: go to DONE.
  - Otherwise pick the largest denomination d with d<=remaining and count>0, set coin_sel and coin_valid=1, go to EJECT.
  - No such d: go to ERROR.
REQ-023 EJECT: SHALL hold coin_valid and coin_sel stable until coin_ack is sampled high.
REQ-024 EJECT on coin_ack: on that edge SHALL subtract the denomination value from remaining, decrement the selected count, drop coin_valid and go to SELECT.
REQ-025 SHALL ignore coin_ack outside EJECT.
REQ-026 EJECT timeout: if coin_ack stays low for ACK_TIMEOUT consecutive cycles in EJECT, SHALL drop coin_valid and go to ERROR, leaving the count and remaining unchanged.
REQ-027 DONE: dispense_done=1 for exactly one cycle, busy=0 and remaining=0 on the next edge, return to IDLE.
REQ-028 ERROR: dispense_error=1 for exactly one cycle, busy=0, remaining holds the shortfall until the next accepted start, return to IDLE.
REQ-029 refill_en SHALL take effect only in IDLE, incrementing the selected count and saturating at 15; it SHALL be ignored in all other states.
REQ-030 Arithmetic SHALL be 5-bit unsigned; subtraction never underflows because d<=remaining is enforced in SELECT.
REQ-031 inv_empty SHALL be a direct decode of the counters, updated on the edge after the count changes.
REQ-032 Latency: one coin costs 2 cycles plus the ack wait; done asserts one cycle after the final ack-to-SELECT cycle.

Reset
REQ-033 When rst is high at an edge, the block SHALL set state=IDLE, all outputs 0, remaining=0, every count=INIT_COUNT and inv_empty=0000.
REQ-034 Reset asserted mid-EJECT SHALL drop coin_valid on that same edge, with no done or error pulse.
REQ-035 rst SHALL take priority over every other input.

Verification
REQ-036 Full inventory, amount 18, ack 3 cycles after each coin_valid -> coins 10,5,2,1 in order, done pulse, remaining=0, all counts 7.
REQ-037 Amount 0 -> done=1 exactly one cycle after the valid edge, coin_valid never asserted, busy never asserted.
REQ-038 Refill to counts {1:2, 2:0, 5:0, 10:0} (reset then 3 inputs drained), amount 3 -> two 1-coins, error pulse, remaining=1, inv_empty=1111.
REQ-039 Amount 18, coin_ack held low -> error after exactly 200 cycles in EJECT, remaining=18, 10-count=8.
REQ-040 rst during EJECT of amount 20 -> coin_valid=0 next cycle, counts back to 8, no done or error; a second change_valid mid-dispense is ignored.
REQ-041 refill_en on 10 at count 15 in IDLE -> stays 15; refill_en while busy -> count unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays change_amount out of four 4-bit inventories, largest coin first.
// Latency: 2 cycles per coin plus the ack wait; backpressure: coin_valid/coin_sel hold until coin_ack or ACK_TIMEOUT.
module change_dispenser #(
  parameter int INIT_COUNT  = 8,
  parameter int ACK_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] change_amount,
  input  logic       change_valid,
  input  logic       coin_ack,
  input  logic       refill_en,
  input  logic [1:0] refill_sel,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  output logic       dispense_busy,
  output logic       dispense_done,
  output logic       dispense_error,
  output logic [4:0] remaining,
  output logic [3:0] inv_empty
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, ERROR} state_t;

  localparam logic [3:0] INIT_CNT = 4'(INIT_COUNT);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [3:0] cnt [4];
  logic [7:0] wait_cnt;
  logic       pick_ok;
  logic [1:0] pick_sel;

  function automatic logic [4:0] denom_val(input logic [1:0] sel);
    case (sel)
      2'd0:    return 5'd1;
      2'd1:    return 5'd2;
      2'd2:    return 5'd5;
      default: return 5'd10;
    endcase
  endfunction

  // Ascending scan so the largest eligible denomination is the last one to win.
  always_comb begin
    pick_ok  = 1'b0;
    pick_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (denom_val(2'(i)) <= remaining && cnt[i] != 4'd0) begin
        pick_ok  = 1'b1;
        pick_sel = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      coin_valid     <= 1'b0;
      coin_sel       <= 2'd0;
      dispense_busy  <= 1'b0;
      dispense_done  <= 1'b0;
      dispense_error <= 1'b0;
      remaining      <= 5'd0;
      inv_empty      <= 4'd0;
      wait_cnt       <= 8'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= INIT_CNT;
    end else begin
      for (int i = 0; i < 4; i++) inv_empty[i] <= (cnt[i] == 4'd0);

      case (state)
        IDLE: begin
          if (refill_en && cnt[refill_sel] != 4'hF)
            cnt[refill_sel] <= cnt[refill_sel] + 4'd1;
          if (change_valid) begin
            if (change_amount != 5'd0) begin
              remaining     <= change_amount;
              dispense_busy <= 1'b1;
              state         <= SELECT;
            end else begin
              dispense_done <= 1'b1;
              state         <= DONE;
            end
          end
        end

        SELECT: begin
          if (remaining == 5'd0) begin
            dispense_done <= 1'b1;
            state         <= DONE;
          end else if (pick_ok) begin
            coin_sel   <= pick_sel;
            coin_valid <= 1'b1;
            wait_cnt   <= 8'd0;
            state      <= EJECT;
          end else begin
            dispense_error <= 1'b1;
            state          <= ERROR;
          end
        end

        EJECT: begin
          if (coin_ack) begin
            remaining     <= remaining - denom_val(coin_sel);
            cnt[coin_sel] <= cnt[coin_sel] - 4'd1;
            coin_valid    <= 1'b0;
            state         <= SELECT;
          end else if (wait_cnt == ACK_LAST) begin
            // Jam: the coin never left, so inventory and remaining stay as they were.
            coin_valid     <= 1'b0;
            dispense_error <= 1'b1;
            state          <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          dispense_done <= 1'b0;
          dispense_busy <= 1'b0;
          remaining     <= 5'd0;
          state         <= IDLE;
        end

        ERROR: begin
          dispense_error <= 1'b0;
          dispense_busy  <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a per-cycle reference model plus hand-computed literal expectations.
module tb_change_dispenser;

  localparam int ACK_TO = 200;
  localparam int INIT   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] change_amount;
  logic       change_valid;
  logic       coin_ack;
  logic       refill_en;
  logic [1:0] refill_sel;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       dispense_busy;
  logic       dispense_done;
  logic       dispense_error;
  logic [4:0] remaining;
  logic [3:0] inv_empty;

  change_dispenser #(.INIT_COUNT(INIT), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .change_amount  (change_amount),
    .change_valid   (change_valid),
    .coin_ack       (coin_ack),
    .refill_en      (refill_en),
    .refill_sel     (refill_sel),
    .coin_valid     (coin_valid),
    .coin_sel       (coin_sel),
    .dispense_busy  (dispense_busy),
    .dispense_done  (dispense_done),
    .dispense_error (dispense_error),
    .remaining      (remaining),
    .inv_empty      (inv_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ejector stand-in: acks ack_delay cycles after coin_valid rises; ack_delay=0 models a jam.
  int   ack_delay;
  int   ack_cnt = 0;
  logic auto_ack = 1'b0;
  logic force_ack;
  assign coin_ack = auto_ack | force_ack;

  always @(negedge clk) begin
    if (coin_valid && ack_delay != 0) begin
      ack_cnt  = ack_cnt + 1;
      auto_ack = (ack_cnt >= ack_delay);
    end else begin
      ack_cnt  = 0;
      auto_ack = 1'b0;
    end
  end

  // Reference model: coins are paid greedily from an integer inventory.
  int         denom [4] = '{1, 2, 5, 10};
  int         inv   [4];
  logic       e_cv, e_busy, e_done, e_err;
  logic [1:0] e_sel;
  int         e_rem;
  logic [3:0] e_empty;
  bit         m_decide;
  int         m_wait;

  always @(posedge clk) begin
    logic [3:0] emp;
    int         pick;
    for (int k = 0; k < 4; k++) emp[k] = (inv[k] == 0);
    if (rst) begin
      for (int k = 0; k < 4; k++) inv[k] = INIT;
      e_cv = 0; e_sel = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_rem = 0; e_empty = 0; m_decide = 0; m_wait = 0;
    end else begin
      if (e_done) begin
        e_done = 0; e_busy = 0; e_rem = 0;
      end else if (e_err) begin
        e_err = 0; e_busy = 0;
      end else if (m_decide) begin
        m_decide = 0;
        if (e_rem == 0) e_done = 1;
        else begin
          pick = -1;
          for (int k = 3; k >= 0; k--)
            if (pick < 0 && denom[k] <= e_rem && inv[k] > 0) pick = k;
          if (pick < 0) e_err = 1;
          else begin
            e_cv = 1; e_sel = 2'(pick); m_wait = 0;
          end
        end
      end else if (e_cv) begin
        if (coin_ack) begin
          e_rem = e_rem - denom[e_sel];
          inv[e_sel] = inv[e_sel] - 1;
          e_cv = 0;
          m_decide = 1;
        end else begin
          m_wait++;
          if (m_wait == ACK_TO) begin
            e_cv = 0; e_err = 1;
          end
        end
      end else begin
        if (refill_en && inv[refill_sel] < 15) inv[refill_sel] = inv[refill_sel] + 1;
        if (change_valid) begin
          if (change_amount != 0) begin
            e_rem = change_amount; e_busy = 1; m_decide = 1;
          end else e_done = 1;
        end
      end
      e_empty = emp;
    end
  end

  // Event monitor used by the literal checks.
  int   coins[$];
  int   done_cnt = 0, err_cnt = 0, busy_cnt = 0, cv_cycles = 0;
  logic prev_cv = 1'b0;

  always @(negedge clk) begin
    if (coin_valid && !prev_cv) coins.push_back(int'(coin_sel));
    if (coin_valid) cv_cycles++;
    if (dispense_done) done_cnt++;
    if (dispense_error) err_cnt++;
    if (dispense_busy) busy_cnt++;
    prev_cv = coin_valid;
  end

  task automatic start(input int amt);
    change_amount = 5'(amt);
    change_valid  = 1'b1;
    @(negedge clk);
    change_valid  = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!(dispense_done || dispense_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp036 [4] = '{3, 2, 1, 0};
  int drain  [7] = '{30, 30, 20, 30, 10, 16, 6};

  initial begin
    int n0, d0, e0, c0, b0, seen, n;
    logic pv;
    rst = 1'b1; change_amount = 0; change_valid = 0; force_ack = 0;
    refill_en = 0; refill_sel = 0; ack_delay = 3;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("coin_valid", coin_valid, e_cv);
          if (e_cv) chk("coin_sel", coin_sel, e_sel);
          chk("busy", dispense_busy, e_busy);
          chk("done", dispense_done, e_done);
          chk("error", dispense_error, e_err);
          chk("remaining", remaining, e_rem);
          chk("inv_empty", inv_empty, e_empty);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_remaining", remaining, 0);
    chk("rst_inv_empty", inv_empty, 0);
    chk("rst_busy", dispense_busy, 0);
    chk("rst_coin_valid", coin_valid, 0);
    rst = 1'b0;

    // coin_ack outside EJECT must not disturb anything
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;

    // 18 from full inventory -> 10,5,2,1
    n0 = coins.size(); d0 = done_cnt;
    start(18);
    wait_end("r036", 200);
    chk("r036_ncoins", coins.size() - n0, 4);
    for (int i = 0; i < 4; i++) chk("r036_coin", coins[n0 + i], exp036[i]);
    chk("r036_done_pulses", done_cnt - d0, 1);
    chk("r036_remaining", remaining, 0);
    chk("r036_model_inv10", inv[3], 7);

    // zero amount: done on the following cycle only
    n0 = coins.size(); b0 = busy_cnt;
    start(0);
    chk("r037_done_now", dispense_done, 1);
    @(negedge clk);
    chk("r037_done_next", dispense_done, 0);
    chk("r037_no_coin", coins.size() - n0, 0);
    chk("r037_no_busy", busy_cnt - b0, 0);

    // jammed ejector
    pulse_rst();
    ack_delay = 0; c0 = cv_cycles; e0 = err_cnt; n0 = coins.size();
    start(18);
    wait_end("r039", 400);
    chk("r039_eject_cycles", cv_cycles - c0, 200);
    chk("r039_err_pulses", err_cnt - e0, 1);
    chk("r039_first_coin", coins[n0], 3);
    chk("r039_remaining", remaining, 18);
    chk("r039_model_rem", e_rem, 18);
    chk("r039_model_inv10", inv[3], 8);

    // reset mid-EJECT of 20; stray change_valid while busy
    ack_delay = 3;
    pulse_rst();
    d0 = done_cnt; e0 = err_cnt;
    start(20);
    start(7);
    seen = 0; pv = 1'b0; n = 0;
    while (n < 60) begin
      if (coin_valid && !pv) seen++;
      pv = coin_valid;
      if (seen == 2) break;
      @(negedge clk);
      n++;
    end
    chk("r040_second_coin_seen", seen, 2);
    pulse_rst();
    chk("r040_cv_after_rst", coin_valid, 0);
    chk("r040_busy_after_rst", dispense_busy, 0);
    repeat (2) @(negedge clk);
    chk("r040_no_done", done_cnt - d0, 0);
    chk("r040_no_err", err_cnt - e0, 0);

    // drain to {1:2, 2:0, 5:0, 10:0}, which also proves reset restored all counts to 8
    ack_delay = 1;
    for (int i = 0; i < 7; i++) begin
      start(drain[i]);
      wait_end("r038_drain", 200);
    end
    chk("r038_drained_empty", inv_empty, 4'b1110);
    n0 = coins.size(); e0 = err_cnt; d0 = done_cnt;
    start(3);
    wait_end("r038", 100);
    chk("r038_ncoins", coins.size() - n0, 2);
    chk("r038_coin0", coins[n0], 0);
    chk("r038_coin1", coins[n0 + 1], 0);
    chk("r038_err_pulses", err_cnt - e0, 1);
    chk("r038_no_done", done_cnt - d0, 0);
    chk("r038_remaining", remaining, 1);
    chk("r038_inv_empty", inv_empty, 4'b1111);

    // refill while busy is ignored: 10-count 8 -> 7 after one coin, then 7 tens drain it
    pulse_rst();
    ack_delay = 2;
    start(10);
    refill_sel = 2'd3; refill_en = 1'b1;
    repeat (3) @(negedge clk);
    refill_en = 1'b0;
    wait_end("r041_busy", 100);
    start(30); wait_end("r041_a", 200);
    start(30); wait_end("r041_b", 200);
    start(10); wait_end("r041_c", 200);
    chk("r041_tens_drained", inv_empty, 4'b1000);

    // 16 refills in IDLE: count saturates at 15, never wraps
    refill_sel = 2'd3; refill_en = 1'b1;
    repeat (16) @(negedge clk);
    refill_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("r041_saturated_nonempty", inv_empty, 4'b0000);
    chk("r041_model_inv10", inv[3], 15);
    for (int i = 0; i < 5; i++) begin
      start(30);
      wait_end("r041_sat_drain", 200);
    end
    chk("r041_fifteen_tens", inv_empty, 4'b1000);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
